// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-driven initiator for the 8-bit enabled ALU bus.
// Keeps an 8-bit accumulator used as operand a, drives the ALU for exactly one
// cycle per operation, captures the result, and returns it on a valid/ready port.
// Optional feature: define ALU_OP_SEQUENCER_FLAGS_EN to add rsp_zero/rsp_neg.

module alu_op_sequencer #(
    parameter logic [7:0] ACC_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    // command port
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_sel,
    input  logic [7:0] cmd_b,
    // response port
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic [7:0] op_count,
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    output logic       rsp_zero,
    output logic       rsp_neg,
`endif
    // ALU bus
    output logic       alu_en,
    output logic [2:0] alu_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_y
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] cnt_q, cnt_d;
    // ALU bus registers double as the latched command; they hold outside ISSUE
    logic [2:0] sel_q, sel_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;

    // Next-state, handshake and accumulator update
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        a_d       = a_q;
        b_d       = b_q;
        cmd_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = ~rst;
            end
            StIssue: begin
                acc_d   = alu_y;
                state_d = StResp;
            end
            StResp: begin
                // back-to-back: a consumed response frees the slot this cycle
                cmd_ready = ~rst & rsp_ready;
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (cmd_valid && cmd_ready) begin
            if (cmd_load) begin
                acc_d   = cmd_b;
                state_d = StResp;
            end else begin
                sel_d   = cmd_sel;
                a_d     = acc_q;
                b_d     = cmd_b;
                state_d = StIssue;
            end
        end
    end

    // State registers with synchronous reset; reset abandons any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= ACC_INIT;
            cnt_q   <= 8'h00;
            sel_q   <= 3'b000;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    logic zero_q;
    logic neg_q;

    // Result flags registered alongside the accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= (acc_d == 8'h00);
            neg_q  <= acc_d[7];
        end
    end

    assign rsp_zero = zero_q;
    assign rsp_neg  = neg_q;
`endif

    // Outputs decoded from state or taken straight from registers
    assign alu_en    = (state_q == StIssue);
    assign alu_sel   = sel_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_y     = acc_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a cycle-level behavioural model
// checked every cycle, plus literal expectations from hand-computed vectors.

module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_sel;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_y;
    logic [7:0] op_count;
    logic       alu_en;
    logic [2:0] alu_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_y;
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
    logic       rsp_zero;
    logic       rsp_neg;
`endif

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int en_cycles = 0;
    bit chk_en = 0;
    logic [7:0] got[$];

    alu_op_sequencer #(.ACC_INIT(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_sel   (cmd_sel),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .op_count  (op_count),
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
`endif
        .alu_en    (alu_en),
        .alu_sel   (alu_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [2:0] s, input logic [7:0] a,
                                          input logic [7:0] b);
        case (s)
            3'd0:    return 8'h00;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a + b;
            3'd4:    return a - b;
            3'd5:    return a ^ b;
            3'd6:    return ~a;
            default: return 8'hFF;
        endcase
    endfunction

    // ALU on the bus: floats when not enabled
    assign alu_y = alu_en ? alu_fn(alu_sel, alu_a, alu_b) : 8'hzz;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model state: what the sequencer must be doing this cycle
    logic       m_alu_due;
    logic       m_rsp_valid;
    logic [7:0] m_rsp_y;
    logic [7:0] m_acc;
    logic [7:0] m_cnt;
    logic [2:0] m_sel;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic       exp_ready;

    initial begin
        m_alu_due = 0; m_rsp_valid = 0; m_rsp_y = 0; m_acc = 0; m_cnt = 0;
        m_sel = 0; m_a = 0; m_b = 0;
    end

    // Compare process: check at negedge, then advance the model over the next edge
    always @(negedge clk) begin
        exp_ready = !rst && !m_alu_due && (!m_rsp_valid || rsp_ready);
        if (chk_en) begin
            chk("cmd_ready", {7'd0, cmd_ready}, {7'd0, exp_ready});
            chk("rsp_valid", {7'd0, rsp_valid}, {7'd0, m_rsp_valid});
            if (m_rsp_valid) begin
                chk("rsp_y", rsp_y, m_rsp_y);
`ifdef ALU_OP_SEQUENCER_FLAGS_EN
                chk("rsp_zero", {7'd0, rsp_zero}, {7'd0, m_rsp_y == 8'h00});
                chk("rsp_neg", {7'd0, rsp_neg}, {7'd0, m_rsp_y[7]});
`endif
            end
            chk("op_count", op_count, m_cnt);
            chk("alu_en", {7'd0, alu_en}, {7'd0, m_alu_due});
            chk("alu_sel", {5'd0, alu_sel}, {5'd0, m_sel});
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            if (!rst && rsp_valid && rsp_ready) got.push_back(rsp_y);
            if (alu_en) en_cycles++;
        end
        cyc++;

        if (rst) begin
            m_alu_due = 0; m_rsp_valid = 0; m_rsp_y = 8'h00; m_acc = 8'h00; m_cnt = 0;
            m_sel = 0; m_a = 0; m_b = 0;
        end else begin
            if (m_rsp_valid && rsp_ready) begin
                m_cnt = m_cnt + 8'd1;
                m_rsp_valid = 0;
            end
            if (m_alu_due) begin
                m_acc = alu_fn(m_sel, m_a, m_b);
                m_rsp_valid = 1;
                m_rsp_y = m_acc;
                m_alu_due = 0;
            end
            if (cmd_valid && exp_ready) begin
                if (cmd_load) begin
                    m_acc = cmd_b;
                    m_rsp_valid = 1;
                    m_rsp_y = cmd_b;
                end else begin
                    m_alu_due = 1;
                    m_sel = cmd_sel;
                    m_a = m_acc;
                    m_b = cmd_b;
                end
            end
        end
    end

    // Present a command at posedge+1 and hold it until it is accepted
    task automatic do_cmd(input logic ld, input logic [2:0] s, input logic [7:0] bv);
        bit hs = 0;
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_sel   = s;
        cmd_b     = bv;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = cmd_ready;
            @(posedge clk);
            #1;
        end
        if (!hs) begin
            checks++;
            fails++;
            $display("FAIL cmd_accept_timeout at %0t", $time);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] exp_rsp[27];
    int c0;

    initial begin
        exp_rsp = '{8'h4F, 8'h6E,
                    8'h4F, 8'h00, 8'h4F, 8'h0F, 8'h4F, 8'h5F, 8'h4F, 8'h6E,
                    8'h4F, 8'h30, 8'h4F, 8'h50, 8'h4F, 8'hB0, 8'h4F, 8'hFF,
                    8'hFF, 8'h00, 8'h00, 8'hFF,
                    8'h10, 8'h11, 8'h22,
                    8'h33, 8'h44};
        rst = 1; cmd_valid = 0; cmd_load = 0; cmd_sel = 0; cmd_b = 0; rsp_ready = 1;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("reset_cmd_ready", {7'd0, cmd_ready}, 8'h01);
        chk("reset_rsp_valid", {7'd0, rsp_valid}, 8'h00);
        chk("reset_rsp_y", rsp_y, 8'h00);
        chk("reset_alu_a", alu_a, 8'h00);
        @(posedge clk); #1;

        // Load then add
        en_cycles = 0;
        do_cmd(1'b1, 3'd0, 8'h4F);
        do_cmd(1'b0, 3'd3, 8'h1F);
        drain();
        @(negedge clk);
        chk("t1_op_count", op_count, 8'h02);
        chk("t1_alu_en_cycles", en_cycles[7:0], 8'h01);
        @(posedge clk); #1;

        // Op sweep
        for (int s = 0; s < 8; s++) begin
            do_cmd(1'b1, 3'd0, 8'h4F);
            do_cmd(1'b0, s[2:0], 8'h1F);
        end
        drain();

        // Wrap
        do_cmd(1'b1, 3'd0, 8'hFF);
        do_cmd(1'b0, 3'd3, 8'h01);
        do_cmd(1'b1, 3'd0, 8'h00);
        do_cmd(1'b0, 3'd4, 8'h01);
        drain();

        // Backpressure with a command waiting behind the stalled response
        do_cmd(1'b1, 3'd0, 8'h10);
        do_cmd(1'b0, 3'd2, 8'h01);
        rsp_ready = 0;
        cmd_valid = 1; cmd_load = 1; cmd_sel = 3'd0; cmd_b = 8'h22;
        repeat (5) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp_rsp_y", rsp_y, 8'h11);
        chk("bp_cmd_ready", {7'd0, cmd_ready}, 8'h00);
        @(posedge clk); #1;
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", {7'd0, cmd_ready}, 8'h01);
        @(posedge clk); #1;
        cmd_valid = 0;
        drain();

        // Reset during ISSUE
        do_cmd(1'b1, 3'd0, 8'h33);
        do_cmd(1'b0, 3'd3, 8'h05);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'h00);
        chk("rst_alu_en", {7'd0, alu_en}, 8'h00);
        chk("rst_op_count", op_count, 8'h00);
        chk("rst_rsp_y", rsp_y, 8'h00);
        @(posedge clk); #1;
        do_cmd(1'b1, 3'd0, 8'h44);
        drain();

        chk("rsp_total", got.size() > 255 ? 8'hFF : got.size()[7:0], 8'd27);
        for (int i = 0; i < 27 && i < got.size(); i++) chk("rsp_seq", got[i], exp_rsp[i]);

        // op_count wrap with back-to-back loads
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        c0 = cyc;
        for (int i = 0; i < 256; i++) do_cmd(1'b1, 3'd0, i[7:0]);
        chk("load_throughput", (cyc - c0) > 255 ? 8'hFF : (cyc - c0), 8'd255 + 8'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_op_count", op_count, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
